evenzeroes_sched: RTL and testbench

Clocked scheduler that shares one asynchronous dual-rail `evenzeroes_imp` instance between two synchronous requesters. It arbitrates round-robin, then runs the full four-phase dual-rail handshake: drive rail, wait for the parity rail, return to zero, wait for null. It returns the parity result to the winning requester. It sits between the synchronous control domain and the async parity core.

---
 rtl/evenzeroes_pkg.sv | 16 +
 rtl/ez_sync2.sv | 23 ++
 rtl/evenzeroes_sched.sv | 153 +++++++++++++++
 tb/tb_evenzeroes_sched.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/evenzeroes_pkg.sv
// Shared types and constants for the evenzeroes scheduler slice.
package evenzeroes_pkg;

    localparam int EZ_NREQ    = 2;
    localparam int EZ_TIMEOUT = 200;

    typedef enum logic [2:0] {
        IDLE,
        SET,
        WAIT_ACK,
        RTZ,
        WAIT_NULL,
        ERR
    } ez_state_t;

endpackage

// File: rtl/ez_sync2.sv
// Single-bit two-flop synchronizer bringing the async core rails into clk.
module ez_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // NOTE: non-blocking assignments make meta->q a true two-stage shift;
    // blocking here would collapse both flops into one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/evenzeroes_sched.sv
// Round-robin scheduler sharing one async dual-rail evenzeroes core between two requesters.
// Optional handshake timeout: define EVENZEROES_SCHED_TIMEOUT_EN.
module evenzeroes_sched
    import evenzeroes_pkg::*;
#(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = EZ_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [EZ_NREQ-1:0] req_valid_i,
    input  logic [EZ_NREQ-1:0] req_bit_i,
    output logic [EZ_NREQ-1:0] req_ready_o,
    output logic               rsp_valid_o,
    output logic               rsp_id_o,
    output logic               rsp_parity_o,
    output logic               rsp_err_o,
    input  logic               clr_i,
    output logic               bit0_o,
    output logic               bit1_o,
    input  logic               parity0_i,
    input  logic               parity1_i
);

    ez_state_t state, state_nxt;

    logic p0, p1;
    logic ptr, id_q, bit_q, par_q;
    logic gid, accept, latch_par, go_err, timeout_hit;
    logic bit0_nxt, bit1_nxt, rsp_valid_c, rsp_err_c;

    ez_sync2 u_sync_p0 (.clk(clk), .rst_n(rst_n), .d(parity0_i), .q(p0));
    ez_sync2 u_sync_p1 (.clk(clk), .rst_n(rst_n), .d(parity1_i), .q(p1));

    // With both requesting the pointer decides; otherwise the lone requester wins.
    assign gid = (&req_valid_i) ? ptr : req_valid_i[1];

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        latch_par   = 1'b0;
        go_err      = 1'b0;
        bit0_nxt    = bit0_o;
        bit1_nxt    = bit1_o;
        rsp_valid_c = 1'b0;
        rsp_err_c   = 1'b0;
        case (state)
            IDLE: begin
                if (|req_valid_i) begin
                    accept    = 1'b1;
                    state_nxt = SET;
                end
            end
            SET: begin
                bit1_nxt  = bit_q;
                bit0_nxt  = ~bit_q;
                state_nxt = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (p0 && p1) begin
                    go_err = 1'b1;
                end else if (p0 ^ p1) begin
                    latch_par = 1'b1;
                    state_nxt = RTZ;
                end else if (timeout_hit) begin
                    go_err = 1'b1;
                end
            end
            RTZ: begin
                bit0_nxt  = 1'b0;
                bit1_nxt  = 1'b0;
                state_nxt = WAIT_NULL;
            end
            WAIT_NULL: begin
                if (!p0 && !p1) begin
                    rsp_valid_c = 1'b1;
                    state_nxt   = IDLE;
                end else if (timeout_hit) begin
                    go_err = 1'b1;
                end
            end
            ERR: begin
                bit0_nxt = 1'b0;
                bit1_nxt = 1'b0;
                if (clr_i && !p0 && !p1) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // The single error pulse is issued on the cycle ERR is decided.
        if (go_err) begin
            state_nxt   = ERR;
            rsp_valid_c = 1'b1;
            rsp_err_c   = 1'b1;
            bit0_nxt    = 1'b0;
            bit1_nxt    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr    <= 1'b0;
            id_q   <= 1'b0;
            bit_q  <= 1'b0;
            par_q  <= 1'b0;
            bit0_o <= 1'b0;
            bit1_o <= 1'b0;
        end else begin
            bit0_o <= bit0_nxt;
            bit1_o <= bit1_nxt;
            if (accept) begin
                id_q  <= gid;
                bit_q <= req_bit_i[gid];
                ptr   <= ~gid;
            end
            if (latch_par) par_q <= p1;
        end
    end

`ifdef EVENZEROES_SCHED_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] cnt;

    // Cleared on every state change so each wait state starts from zero; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          cnt <= '0;
        else if (state_nxt != state)         cnt <= '0;
        else if (cnt != TIMEOUT_W'(TIMEOUT)) cnt <= cnt + 1'b1;
    end

    assign timeout_hit = (cnt == TIMEOUT_W'(TIMEOUT));
`else
    logic unused_timeout;

    assign unused_timeout = ^{TIMEOUT_W[0], TIMEOUT[0]};
    assign timeout_hit    = 1'b0;
`endif

    // The accept pulse is decoded from IDLE, which is also the reset state, so it
    // is gated by rst_n to keep it low while reset is held.
    assign req_ready_o[0] = accept & rst_n & ~gid;
    assign req_ready_o[1] = accept & rst_n & gid;
    assign rsp_valid_o    = rsp_valid_c;
    assign rsp_id_o       = rsp_valid_c & id_q;
    assign rsp_parity_o   = rsp_valid_c & ~rsp_err_c & par_q;
    assign rsp_err_o      = rsp_err_c;

endmodule

// File: tb/tb_evenzeroes_sched.sv
// Directed bench for evenzeroes_sched with a shift-register model of the async core.
module tb_evenzeroes_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [1:0] req_valid = 2'b00;
    logic [1:0] req_bit = 2'b00;
    logic       clr = 1'b0;
    logic [1:0] req_ready;
    logic       rsp_valid, rsp_id, rsp_parity, rsp_err;
    logic       bit0, bit1;
    logic       parity0, parity1;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Core model: 0 echoes the data rail after 3 cycles, 1 raises both rails, 2 never answers.
    int         core_mode = 0;
    logic [7:0] h0 = 8'h00;
    logic [7:0] h1 = 8'h00;

    evenzeroes_sched #(.TIMEOUT_W(8), .TIMEOUT(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_bit_i(req_bit), .req_ready_o(req_ready),
        .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_parity_o(rsp_parity),
        .rsp_err_o(rsp_err), .clr_i(clr),
        .bit0_o(bit0), .bit1_o(bit1),
        .parity0_i(parity0), .parity1_i(parity1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        h0  <= {h0[6:0], bit0};
        h1  <= {h1[6:0], bit1};
    end

    assign parity0 = (core_mode == 0) ? h0[2] : (core_mode == 1) ? (h0[2] | h1[2]) : 1'b0;
    assign parity1 = (core_mode == 0) ? h1[2] : (core_mode == 1) ? (h0[2] | h1[2]) : 1'b0;

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b00;
        clr       = 1'b0;
        core_mode = 0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_ready(input int budget, output logic [1:0] g, output int at);
        g  = 2'b00;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                g  = req_ready;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_rsp(input int budget, output int at, output logic id, output logic par,
                            output logic err, output int b0_at, output int b1_at, output logic both);
        at = -1; id = 1'b0; par = 1'b0; err = 1'b0; b0_at = -1; b1_at = -1; both = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bit0 && b0_at < 0) b0_at = cyc;
            if (bit1 && b1_at < 0) b1_at = cyc;
            if (bit0 && bit1) both = 1'b1;
            if (rsp_valid) begin
                at = cyc; id = rsp_id; par = rsp_parity; err = rsp_err;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [1:0] g;
        int a;
        req_valid = 2'b11;
        #1 rst_n = 1'b0;
        #2;
        vectors++;
        if ({req_ready, rsp_valid, rsp_id, rsp_parity, rsp_err, bit0, bit1} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %b required 0", {req_ready, rsp_valid, rsp_id, rsp_parity, rsp_err, bit0, bit1});
        end
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(5, g, a);
        vectors++;
        if (g !== 2'b01) begin
            miscompares++;
            $display("FAIL reset_first_grant: got %b required 01", g);
        end
    endtask

    task automatic test_single();
        logic [1:0] g;
        int a, at, b0_at, b1_at;
        logic id, par, err, both;
        do_reset();
        req_valid = 2'b01;
        req_bit   = 2'b01;
        wait_ready(20, g, a);
        vectors++;
        if (g !== 2'b01) begin
            miscompares++;
            $display("FAIL single_grant: got %b required 01", g);
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        wait_rsp(60, at, id, par, err, b0_at, b1_at, both);
        vectors++;
        if (b1_at !== a + 2 || b0_at !== -1 || both !== 1'b0) begin
            miscompares++;
            $display("FAIL single_rails: bit1 at %0d bit0 at %0d both %b, required bit1 at %0d, no bit0", b1_at, b0_at, both, a + 2);
        end
        vectors++;
        if (at !== a + 14) begin
            miscompares++;
            $display("FAIL single_latency: rsp at %0d required %0d", at, a + 14);
        end
        vectors++;
        if ({id, par, err} !== 3'b010) begin
            miscompares++;
            $display("FAIL single_result: id/par/err %b required 010", {id, par, err});
        end
        @(negedge clk);
        vectors++;
        if ({rsp_valid, bit0, bit1} !== 3'b000) begin
            miscompares++;
            $display("FAIL single_after: valid/bit0/bit1 %b required 000", {rsp_valid, bit0, bit1});
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] g, exp_g;
        int a, at, prev_at, b0_at, b1_at;
        logic id, par, err, both;
        do_reset();
        req_valid = 2'b11;
        req_bit   = 2'b10;
        prev_at   = -1;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            wait_ready(30, g, a);
            vectors++;
            if (g !== exp_g) begin
                miscompares++;
                $display("FAIL contention_grant%0d: got %b required %b", k, g, exp_g);
            end
            if (k > 0) begin
                vectors++;
                if (a !== prev_at + 1) begin
                    miscompares++;
                    $display("FAIL contention_b2b%0d: accept at %0d required %0d", k, a, prev_at + 1);
                end
            end
            wait_rsp(60, at, id, par, err, b0_at, b1_at, both);
            vectors++;
            if (at !== a + 14 || {id, par, err} !== {exp_g[1], exp_g[1], 1'b0}) begin
                miscompares++;
                $display("FAIL contention_rsp%0d: at %0d id/par/err %b required at %0d %b",
                         k, at, {id, par, err}, a + 14, {exp_g[1], exp_g[1], 1'b0});
            end
            prev_at = at;
        end
    endtask

    task automatic test_both_rails();
        logic [1:0] g;
        int a, at, b0_at, b1_at, extra, ra;
        logic id, par, err, both;
        do_reset();
        core_mode = 1;
        req_valid = 2'b10;
        req_bit   = 2'b00;
        wait_ready(20, g, a);
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        clr       = 1'b1;
        wait_rsp(40, at, id, par, err, b0_at, b1_at, both);
        vectors++;
        if (g !== 2'b10 || at !== a + 7 || {id, par, err} !== 3'b101) begin
            miscompares++;
            $display("FAIL both_err_pulse: grant %b at %0d id/par/err %b required 10 at %0d 101", g, at, {id, par, err}, a + 7);
        end
        extra = 0;
        ra    = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cyc == a + 8) begin
                vectors++;
                if ({bit0, bit1} !== 2'b00) begin
                    miscompares++;
                    $display("FAIL both_rails_forced: bit0/bit1 %b required 00", {bit0, bit1});
                end
            end
            if (req_ready != 2'b00) begin
                ra = cyc;
                g  = req_ready;
                break;
            end
            if (rsp_valid) extra++;
        end
        vectors++;
        if (extra !== 0) begin
            miscompares++;
            $display("FAIL both_extra_pulses: got %0d required 0", extra);
        end
        vectors++;
        if (ra !== a + 14 || g !== 2'b01) begin
            miscompares++;
            $display("FAIL both_clr_exit: accept at %0d grant %b required at %0d grant 01", ra, g, a + 14);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] g;
        int a, at, b0_at, b1_at;
        logic id, par, err, both;
        do_reset();
        core_mode = 2;
        req_valid = 2'b01;
        req_bit   = 2'b01;
        wait_ready(20, g, a);
        @(posedge clk);
        #1 req_valid = 2'b00;
`ifdef EVENZEROES_SCHED_TIMEOUT_EN
        wait_rsp(40, at, id, par, err, b0_at, b1_at, both);
        vectors++;
        if (at !== a + 12 || {id, err} !== 2'b01) begin
            miscompares++;
            $display("FAIL timeout_pulse: at %0d id/err %b required at %0d 01", at, {id, err}, a + 12);
        end
        @(negedge clk);
        vectors++;
        if ({bit0, bit1} !== 2'b00) begin
            miscompares++;
            $display("FAIL timeout_rails: bit0/bit1 %b required 00", {bit0, bit1});
        end
`else
        wait_rsp(500, at, id, par, err, b0_at, b1_at, both);
        vectors++;
        if (at !== -1) begin
            miscompares++;
            $display("FAIL no_timeout_pulse: rsp at %0d required none", at);
        end
        vectors++;
        if (bit1 !== 1'b1) begin
            miscompares++;
            $display("FAIL no_timeout_hold: bit1 %b required 1", bit1);
        end
`endif
    endtask

    task automatic test_reset_mid();
        logic [1:0] g;
        int a, pulses;
        do_reset();
        req_valid = 2'b01;
        req_bit   = 2'b01;
        wait_ready(20, g, a);
        @(posedge clk);
        #1 req_valid = 2'b00;
        for (int i = 0; i < 20 && cyc < a + 4; i++) @(negedge clk);
        vectors++;
        if (bit1 !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_wait_ack_rail: bit1 %b required 1", bit1);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bit0, bit1} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_rail_drop: bit0/bit1 %b required 00", {bit0, bit1});
        end
        do_reset();
        req_valid = 2'b01;
        wait_ready(20, g, a);
        @(posedge clk);
        #1 req_valid = 2'b00;
        for (int i = 0; i < 20 && cyc < a + 10; i++) @(negedge clk);
        req_valid = 2'b11;
        rst_n     = 1'b0;
        #1;
        vectors++;
        if ({req_ready, rsp_valid, rsp_id, rsp_parity, rsp_err, bit0, bit1} !== 9'b0) begin
            miscompares++;
            $display("FAIL rst_wait_null_outputs: got %b required 0", {req_ready, rsp_valid, rsp_id, rsp_parity, rsp_err, bit0, bit1});
        end
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid || req_ready != 2'b00) pulses++;
        end
        vectors++;
        if (pulses !== 0) begin
            miscompares++;
            $display("FAIL rst_held_quiet: %0d active cycles required 0", pulses);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_ready(5, g, a);
        vectors++;
        if (g !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_pointer: grant %b required 01", g);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_both_rails();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
